// File: rtl/timer_bank.sv
// timer_bank: NCH-channel memory-mapped timer. Each channel has a prescaler,
// an up-counter, a compare register and one-shot/periodic mode. Match flags are
// sticky W1C bits in STATUS; irq is the OR of STATUS masked by IRQ_EN.
// Optional input capture is built when TIMER_BANK_CAPTURE_EN is defined.
module timer_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [5:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [NCH-1:0]   cap_in,
  output logic [NCH-1:0]   flag,
  output logic             irq
);

  localparam logic [15:0] CH_MASK = 16'((17'd1 << NCH) - 17'd1);
`ifdef TIMER_BANK_CAPTURE_EN
  localparam logic [15:0] ST_MASK = CH_MASK | (CH_MASK << 8);
`else
  localparam logic [15:0] ST_MASK = CH_MASK;
`endif

  logic [NCH-1:0]   en_r;
  logic [NCH-1:0]   per_r;
  logic [PRE_W-1:0] pre_r     [NCH];
  logic [PRE_W-1:0] presc_r   [NCH];
  logic [WIDTH-1:0] count_r   [NCH];
  logic [WIDTH-1:0] compare_r [NCH];
  logic [15:0]      status_r;
  logic [15:0]      irq_en_r;

  logic             chan_sel_s;
  logic [1:0]       reg_s;
  logic [NCH-1:0]   hit_s;
  logic [NCH-1:0]   wr_ctrl_s;
  logic [NCH-1:0]   wr_count_s;
  logic [NCH-1:0]   wr_cmp_s;
  logic [NCH-1:0]   tick_s;
  logic [NCH-1:0]   match_s;
  logic [NCH-1:0]   cap_edge_s;
  logic [15:0]      set_s;
  logic [15:0]      clr_s;
  logic [31:0]      chan_word_s [NCH];
  logic             unused_s;

  // Bits that only matter for some parameter/feature combinations
  assign unused_s = ^{wdata[31:16], cap_in};

  assign reg_s      = addr[1:0];
  assign chan_sel_s = (addr[5] == 1'b0) && ({29'd0, addr[4:2]} < 32'(NCH));

  // Decode per-channel selects, write strobes and tick/match events
  always_comb begin
    hit_s      = '0;
    wr_ctrl_s  = '0;
    wr_count_s = '0;
    wr_cmp_s   = '0;
    tick_s     = '0;
    match_s    = '0;
    for (int n = 0; n < NCH; n++) begin
      hit_s[n]      = chan_sel_s && (addr[4:2] == 3'(n));
      wr_ctrl_s[n]  = we && hit_s[n] && (reg_s == 2'd0);
      wr_count_s[n] = we && hit_s[n] && (reg_s == 2'd1);
      wr_cmp_s[n]   = we && hit_s[n] && (reg_s == 2'd2);
      tick_s[n]     = en_r[n] && (presc_r[n] == pre_r[n]);
      match_s[n]    = tick_s[n] && (count_r[n] == compare_r[n]);
    end
  end

  // Channel state: software writes take priority over tick/match updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r  <= '0;
      per_r <= '0;
      for (int n = 0; n < NCH; n++) begin
        pre_r[n]     <= '0;
        presc_r[n]   <= '0;
        count_r[n]   <= '0;
        compare_r[n] <= '1;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (wr_ctrl_s[n]) begin
          en_r[n]  <= wdata[0];
          per_r[n] <= wdata[1];
          pre_r[n] <= wdata[8 +: PRE_W];
        end else if (match_s[n] && !per_r[n]) begin
          en_r[n] <= 1'b0;
        end
        if (wr_ctrl_s[n] || wr_count_s[n] || tick_s[n]) begin
          presc_r[n] <= '0;
        end else if (en_r[n]) begin
          presc_r[n] <= presc_r[n] + PRE_W'(1);
        end
        if (wr_count_s[n]) begin
          count_r[n] <= wdata[WIDTH-1:0];
        end else if (match_s[n] && per_r[n]) begin
          count_r[n] <= '0;
        end else if (tick_s[n] && !match_s[n]) begin
          count_r[n] <= count_r[n] + WIDTH'(1);
        end
        if (wr_cmp_s[n]) begin
          compare_r[n] <= wdata[WIDTH-1:0];
        end
      end
    end
  end

`ifdef TIMER_BANK_CAPTURE_EN
  logic [NCH-1:0]   sync1_r;
  logic [NCH-1:0]   sync2_r;
  logic [NCH-1:0]   sync3_r;
  logic [WIDTH-1:0] capture_r [NCH];

  // Two-flop synchronizer plus a delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      sync3_r <= '0;
    end else begin
      sync1_r <= cap_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign cap_edge_s = sync2_r & ~sync3_r;

  // Snapshot COUNT on a detected capture edge, independent of EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        capture_r[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (cap_edge_s[n]) begin
          capture_r[n] <= count_r[n];
        end
      end
    end
  end
`else
  assign cap_edge_s = '0;
`endif

  // Hardware set and W1C clear requests for STATUS
  always_comb begin
    set_s = 16'd0;
    set_s[NCH-1:0] = match_s;
`ifdef TIMER_BANK_CAPTURE_EN
    set_s[8 +: NCH] = cap_edge_s;
`endif
    if (we && (addr == 6'h20)) begin
      clr_s = wdata[15:0];
    end else begin
      clr_s = 16'd0;
    end
  end

  // STATUS (set beats clear) and IRQ_EN; unimplemented bits stay 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_r <= 16'd0;
      irq_en_r <= 16'd0;
    end else begin
      status_r <= ((status_r & ~clr_s) | set_s) & ST_MASK;
      if (we && (addr == 6'h21)) begin
        irq_en_r <= wdata[15:0] & ST_MASK;
      end
    end
  end

  // Assemble each channel's word for the currently addressed register
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      chan_word_s[n] = 32'd0;
      case (reg_s)
        2'd0: begin
          chan_word_s[n][0]          = en_r[n];
          chan_word_s[n][1]          = per_r[n];
          chan_word_s[n][8 +: PRE_W] = pre_r[n];
        end
        2'd1:    chan_word_s[n] = 32'(count_r[n]);
        2'd2:    chan_word_s[n] = 32'(compare_r[n]);
`ifdef TIMER_BANK_CAPTURE_EN
        default: chan_word_s[n] = 32'(capture_r[n]);
`else
        default: chan_word_s[n] = 32'd0;
`endif
      endcase
    end
  end

  // Combinational read mux; unmapped addresses read 0
  always_comb begin
    case (addr)
      6'h20:   rdata = {16'd0, status_r};
      6'h21:   rdata = {16'd0, irq_en_r};
      default: begin
        rdata = 32'd0;
        for (int n = 0; n < NCH; n++) begin
          rdata = rdata | (chan_word_s[n] & {32{hit_s[n]}});
        end
      end
    endcase
  end

  assign flag = status_r[NCH-1:0];
  assign irq  = |(status_r & irq_en_r);

endmodule
